// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types, default sizes and helpers for the RSA sequencer
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        START,
        WAIT,
        DRAIN,
        DONE
    } state_e;

    localparam int X_DEF  = 3;
    localparam int N_DEF  = 4;
    localparam int Y_DEF  = 3;
    localparam int L_LOAD = ((X_DEF > Y_DEF) ? X_DEF : Y_DEF) * N_DEF;
    localparam int N_RES  = X_DEF * Y_DEF;

    // Returns at least 1 so a degenerate size still yields a legal vector.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rsa_feed_stage.sv
// rtl/rsa_feed_stage.sv - one-cycle read-valid delay with zero-gated buffer data
module rsa_feed_stage #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic         clr_i,
    input  logic         rd_i,
    input  logic [W-1:0] data_i,
    output logic         val_o,
    output logic [W-1:0] data_o
);

    logic val_q, val_d;

    always_comb begin
        val_d = clr_i ? 1'b0 : rd_i;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) val_q <= 1'b0;
        else         val_q <= val_d;
    end

    assign val_o  = val_q;
    assign data_o = val_q ? data_i : '0;

endmodule

// File: rtl/rsa_ctrl.sv
// rtl/rsa_ctrl.sv - job sequencer: operand load, array start, latency wait, result drain
module rsa_ctrl
    import rsa_pkg::*;
#(
    parameter int X       = 3,
    parameter int N       = 4,
    parameter int Y       = 3,
    parameter int IN_LEN  = 4,
    parameter int OUT_LEN = 8,
    parameter int BUF_AW  = 4,
    parameter int LAT     = X + Y + N
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic                      cmd_val,
    output logic                      cmd_rdy,
    input  logic                      cmd_abort,
    output logic                      xbuf_rd,
    output logic [BUF_AW-1:0]         xbuf_addr,
    input  logic [IN_LEN-1:0]         xbuf_data,
    output logic                      ybuf_rd,
    output logic [BUF_AW-1:0]         ybuf_addr,
    input  logic [IN_LEN-1:0]         ybuf_data,
    output logic                      Xin_val,
    output logic [IN_LEN-1:0]         Xin_data,
    output logic                      Yin_val,
    output logic [IN_LEN-1:0]         Yin_data,
    output logic                      SA_start,
    input  logic [OUT_LEN-1:0]        sa_out_data,
    output logic                      res_val,
    output logic [OUT_LEN-1:0]        res_data,
    output logic [clog2(X*Y)-1:0]     res_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int L_JOB = max_int(X, Y) * N;
    localparam int NR    = X * Y;
    localparam int CW    = clog2(max_int(max_int(L_JOB, LAT), NR) + 1);
    localparam int IW    = clog2(NR);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            abort_clr;

    assign abort_clr = cmd_abort && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One shared counter walks LOAD addresses, WAIT latency and DRAIN indices.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_val) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cnt_q == CW'(L_JOB - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP:   state_d = START;
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == CW'(LAT - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(NR - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        cmd_rdy   = (state_q == IDLE);
        busy      = (state_q != IDLE);
        xbuf_rd   = (state_q == LOAD) && (cnt_q < CW'(X * N));
        ybuf_rd   = (state_q == LOAD) && (cnt_q < CW'(Y * N));
        xbuf_addr = xbuf_rd ? BUF_AW'(cnt_q) : '0;
        ybuf_addr = ybuf_rd ? BUF_AW'(cnt_q) : '0;
        SA_start  = (state_q == START);
        res_val   = (state_q == DRAIN);
        res_data  = res_val ? sa_out_data : '0;
        res_idx   = res_val ? IW'(cnt_q) : '0;
        done      = (state_q == DONE);
    end

    rsa_feed_stage #(.W(IN_LEN)) u_feed_x (
        .clk     (clk),
        .sys_rst (sys_rst),
        .clr_i   (abort_clr),
        .rd_i    (xbuf_rd),
        .data_i  (xbuf_data),
        .val_o   (Xin_val),
        .data_o  (Xin_data)
    );

    rsa_feed_stage #(.W(IN_LEN)) u_feed_y (
        .clk     (clk),
        .sys_rst (sys_rst),
        .clr_i   (abort_clr),
        .rd_i    (ybuf_rd),
        .data_i  (ybuf_data),
        .val_o   (Yin_val),
        .data_o  (Yin_data)
    );

endmodule

// File: tb/tb_rsa_ctrl.sv
// tb/tb_rsa_ctrl.sv - randomized and directed bench for rsa_ctrl with a timeline reference model
module tb_rsa_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst, cmd_val, cmd_abort;
    logic [7:0] sa_out;

    logic       rdy0, busy0, xrd0, yrd0, xv0, yv0, sa0, rv0, dn0;
    logic [3:0] xa0, ya0, xb0, yb0, xd0, yd0, ri0;
    logic [7:0] rd0;

    logic       rdy1, busy1, xrd1, yrd1, xv1, yv1, sa1, rv1, dn1;
    logic [3:0] xa1, ya1, xb1, yb1, xd1, yd1;
    logic [2:0] ri1;
    logic [7:0] rd1;

    rsa_ctrl u_dut0 (
        .clk(clk), .sys_rst(sys_rst), .cmd_val(cmd_val), .cmd_rdy(rdy0), .cmd_abort(cmd_abort),
        .xbuf_rd(xrd0), .xbuf_addr(xa0), .xbuf_data(xb0),
        .ybuf_rd(yrd0), .ybuf_addr(ya0), .ybuf_data(yb0),
        .Xin_val(xv0), .Xin_data(xd0), .Yin_val(yv0), .Yin_data(yd0),
        .SA_start(sa0), .sa_out_data(sa_out),
        .res_val(rv0), .res_data(rd0), .res_idx(ri0), .busy(busy0), .done(dn0)
    );

    rsa_ctrl #(.Y(2)) u_dut1 (
        .clk(clk), .sys_rst(sys_rst), .cmd_val(cmd_val), .cmd_rdy(rdy1), .cmd_abort(cmd_abort),
        .xbuf_rd(xrd1), .xbuf_addr(xa1), .xbuf_data(xb1),
        .ybuf_rd(yrd1), .ybuf_addr(ya1), .ybuf_data(yb1),
        .Xin_val(xv1), .Xin_data(xd1), .Yin_val(yv1), .Yin_data(yd1),
        .SA_start(sa1), .sa_out_data(sa_out),
        .res_val(rv1), .res_data(rd1), .res_idx(ri1), .busy(busy1), .done(dn1)
    );

    logic [3:0] memx [16];
    logic [3:0] memy [16];
    logic [3:0] xp0, yp0, xp1, yp1;

    // Operand buffers: registered read, garbage on idle cycles to expose missing zero-gating.
    always @(negedge clk) begin
        xp0 = xrd0 ? memx[xa0] : 4'($urandom);
        yp0 = yrd0 ? memy[ya0] : 4'($urandom);
        xp1 = xrd1 ? memx[xa1] : 4'($urandom);
        yp1 = yrd1 ? memy[ya1] : 4'($urandom);
    end

    always @(posedge clk) begin
        #1;
        xb0 = xp0; yb0 = yp0; xb1 = xp1; yb1 = yp1;
        sa_out = 8'($urandom);
    end

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    bit m_act [2];
    int m_d   [2];
    int p_y   [2] = '{3, 2};
    int p_lat [2] = '{10, 9};

    function automatic int job_len(input int x, input int y, input int lat);
        return ((x > y) ? x : y) * 4 + lat + 3 + x * y;
    endfunction

    // Expected outputs from the job timeline: d=1 is the first load cycle.
    function automatic logic [36:0] exp_out(input int x, input int y, input int lat,
                                            input bit act, input int d);
        int         l, dr0, dn;
        bit         xr, yr, xv, yv, sa, rv, dnb;
        logic [3:0] xa, ya, xd, yd, ri;
        logic [7:0] rdat;
        l    = ((x > y) ? x : y) * 4;
        dr0  = l + lat + 3;
        dn   = dr0 + x * y;
        xr   = act && d >= 1 && d <= x * 4;
        yr   = act && d >= 1 && d <= y * 4;
        xa   = xr ? 4'(d - 1) : 4'd0;
        ya   = yr ? 4'(d - 1) : 4'd0;
        xv   = act && d >= 2 && d <= x * 4 + 1;
        yv   = act && d >= 2 && d <= y * 4 + 1;
        xd   = xv ? memx[d - 2] : 4'd0;
        yd   = yv ? memy[d - 2] : 4'd0;
        sa   = act && d == l + 2;
        rv   = act && d >= dr0 && d < dn;
        rdat = rv ? sa_out : 8'd0;
        ri   = rv ? 4'(d - dr0) : 4'd0;
        dnb  = act && d == dn;
        return {!act, act, xr, xa, yr, ya, xv, xd, yv, yd, sa, rv, rdat, ri, dnb};
    endfunction

    logic [36:0] e0, a0, e1, a1;

    always @(negedge clk) begin
        if (chk_en) begin
            e0 = exp_out(3, 3, 10, m_act[0], m_d[0]);
            a0 = {rdy0, busy0, xrd0, xa0, yrd0, ya0, xv0, xd0, yv0, yd0, sa0, rv0, rd0, ri0, dn0};
            e1 = exp_out(3, 2, 9, m_act[1], m_d[1]);
            a1 = {rdy1, busy1, xrd1, xa1, yrd1, ya1, xv1, xd1, yv1, yd1, sa1, rv1, rd1, 1'b0, ri1, dn1};
            n_assert++;
            if (a0 !== e0) begin
                n_fail++;
                $display("FAIL model_dut0 t=%0t d=%0d got=%h expected=%h", $time, m_d[0], a0, e0);
            end
            n_assert++;
            if (a1 !== e1) begin
                n_fail++;
                $display("FAIL model_dut1 t=%0t d=%0d got=%h expected=%h", $time, m_d[1], a1, e1);
            end
            for (int i = 0; i < 2; i++) begin
                if (sys_rst) begin
                    m_act[i] = 1'b0;
                end else if (m_act[i]) begin
                    if (cmd_abort || m_d[i] == job_len(3, p_y[i], p_lat[i])) m_act[i] = 1'b0;
                    else m_d[i] = m_d[i] + 1;
                end else if (cmd_val) begin
                    m_act[i] = 1'b1;
                    m_d[i]   = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int expv);
        n_assert++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    int sa_at, rf, rc, dn_at, rdy_c1, rdy_c35, xsum;
    int xvc1, yvc1, rc1, dn1_at, y1first, ysum1, ygate1;
    int last0, last1, ndone0;

    initial begin
        sys_rst = 1'b1; cmd_val = 1'b0; cmd_abort = 1'b0; sa_out = 8'd0;
        xb0 = 0; yb0 = 0; xb1 = 0; yb1 = 0;
        m_act[0] = 0; m_act[1] = 0; m_d[0] = 0; m_d[1] = 0;
        for (int a = 0; a < 16; a++) begin
            memx[a] = 4'(a + 1);
            memy[a] = 4'(a + 1);
        end
        tick();
        chk_en = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("rst_cmd_rdy", int'(rdy0), 1);
        chk("rst_busy", int'(busy0), 0);
        tick();

        // Single job from cycle 0 on both instances.
        cmd_val = 1'b1; tick(); cmd_val = 1'b0;
        sa_at = -1; rf = -1; rc = 0; dn_at = -1; xsum = 0;
        xvc1 = 0; yvc1 = 0; rc1 = 0; dn1_at = -1; y1first = -1; ysum1 = 0; ygate1 = 0;
        for (int i = 1; i <= 36; i++) begin
            #2;
            if (sa0 && sa_at < 0) sa_at = i;
            if (rv0) begin rc++; if (rf < 0) rf = i; end
            if (dn0) dn_at = i;
            if (i == 1) rdy_c1 = int'(rdy0);
            if (i == 35) rdy_c35 = int'(rdy0);
            if (xv0) xsum += int'(xd0);
            if (xv1) xvc1++;
            if (yv1) begin yvc1++; ysum1 += int'(yd1); if (y1first < 0) y1first = i; end
            if (!yv1 && yd1 != 0) ygate1++;
            if (rv1) rc1++;
            if (dn1) dn1_at = i;
            tick();
        end
        chk("cmd_rdy_c1", rdy_c1, 0);
        chk("sa_start_cycle", sa_at, 14);
        chk("res_first_cycle", rf, 25);
        chk("res_count", rc, 9);
        chk("done_cycle", dn_at, 34);
        chk("cmd_rdy_c35", rdy_c35, 1);
        chk("xin_data_sum", xsum, 78);
        chk("y2_xin_cnt", xvc1, 12);
        chk("y2_yin_cnt", yvc1, 8);
        chk("y2_yin_first", y1first, 2);
        chk("y2_yin_sum", ysum1, 36);
        chk("y2_yin_gate", ygate1, 0);
        chk("y2_res_cnt", rc1, 6);
        chk("y2_done_cycle", dn1_at, 30);

        // Abort in WAIT at cycle 18, restart at 19.
        cmd_val = 1'b1; tick(); cmd_val = 1'b0;
        for (int i = 1; i < 18; i++) tick();
        cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
        #2;
        chk("abort_cmd_rdy", int'(rdy0), 1);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_y2_cmd_rdy", int'(rdy1), 1);
        cmd_val = 1'b1; tick(); cmd_val = 1'b0;
        dn_at = -1; rf = -1;
        for (int i = 20; i <= 56; i++) begin
            #2;
            if (dn0) dn_at = i;
            if (rv0 && rf < 0) rf = i;
            tick();
        end
        chk("restart_res_first", rf, 44);
        chk("restart_done_cycle", dn_at, 53);

        // Reset mid-LOAD with cmd_val held, then continuous cmd_val.
        cmd_val = 1'b1; tick(); cmd_val = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        sys_rst = 1'b1; cmd_val = 1'b1; tick();
        #2;
        chk("rst_load_cmd_rdy", int'(rdy0), 1);
        chk("rst_load_xrd", int'(xrd0), 0);
        chk("rst_load_busy", int'(busy0), 0);
        sys_rst = 1'b0; tick();
        #2;
        chk("post_rst_busy", int'(busy0), 1);
        chk("post_rst_xrd", int'(xrd0), 1);
        last0 = -1; last1 = -1; ndone0 = 0;
        for (int i = 7; i <= 156; i++) begin
            if (dn0) begin
                ndone0++;
                if (last0 >= 0) chk("period_dut0", i - last0, 35);
                last0 = i;
            end
            if (dn1) begin
                if (last1 >= 0) chk("period_dut1", i - last1, 31);
                last1 = i;
            end
            tick();
            #2;
        end
        chk("held_cmd_jobs", ndone0, 4);
        cmd_val = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        // Randomized traffic against the model.
        for (int a = 0; a < 16; a++) begin
            memx[a] = 4'($urandom);
            memy[a] = 4'($urandom);
        end
        for (int i = 0; i < 3000; i++) begin
            sys_rst   = ($urandom_range(299) == 0);
            cmd_abort = ($urandom_range(59) == 0);
            cmd_val   = ($urandom_range(2) == 0);
            tick();
        end
        sys_rst = 1'b0; cmd_abort = 1'b0; cmd_val = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_ctrl.md
Name: rsa_ctrl

Overview:
Sequencer for the RSA systolic-array datapath. On a command it streams the X-side and Y-side operands from two local operand buffers into the array, pulses SA_start and waits out the array latency. It then captures the X*Y result words from out_data and presents them as an indexed result stream, followed by a done pulse. It sits between the operand/result buffers and the RSA instance.

Parameters:
X, 3, array rows (X-side operand vectors)
N, 4, inner dimension (words per operand vector)
Y, 3, array columns (Y-side operand vectors)
IN_LEN, 4, operand word width
OUT_LEN, 8, result word width
BUF_AW, 4, operand buffer address width; must satisfy 2**BUF_AW >= max(X,Y)*N
LAT, 10, cycles from SA_start cycle to first valid out_data word (default X+Y+N)

Ports:
clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
cmd_val  in  1  start-job request
cmd_rdy  out  1  controller idle, can accept a command
cmd_abort  in  1  abandon the current job
xbuf_rd  out  1  X buffer read enable
xbuf_addr  out  BUF_AW  X buffer read address
xbuf_data  in  IN_LEN  X buffer read data, valid one cycle after xbuf_rd
ybuf_rd  out  1  Y buffer read enable
ybuf_addr  out  BUF_AW  Y buffer read address
ybuf_data  in  IN_LEN  Y buffer read data, valid one cycle after ybuf_rd
Xin_val  out  1  to RSA Xin_val
Xin_data  out  IN_LEN  to RSA Xin_data
Yin_val  out  1  to RSA Yin_val
Yin_data  out  IN_LEN  to RSA Yin_data
SA_start  out  1  to RSA SA_start, single-cycle pulse
sa_out_data  in  OUT_LEN  from RSA out_data
res_val  out  1  result word valid
res_data  out  OUT_LEN  result word
res_idx  out  clog2(X*Y)  result index, row-major (0..X*Y-1)
busy  out  1  job in progress
done  out  1  single-cycle job-complete pulse

Behaviour:
- Reset: state IDLE and all counters 0. Every output is 0 except cmd_rdy=1. Reset takes effect on the next edge regardless of state and wins over every other input.
- Let L = max(X,Y)*N. Accept occurs when cmd_val && cmd_rdy at an edge. cmd_rdy=1 only in IDLE. busy = !(state==IDLE).
- IDLE -> LOAD on accept.
- LOAD: lasts L cycles, counter k=0..L-1.
  - xbuf_rd=(k<X*N) with xbuf_addr=k.
  - ybuf_rd=(k<Y*N) with ybuf_addr=k.
  - Addresses are 0 when the corresponding read is low.
- LOAD -> GAP after k=L-1. GAP lasts 1 cycle; it is the cycle in which the last read data is presented.
- Xin_val is xbuf_rd delayed one cycle, and Xin_data = xbuf_data, passed through combinationally. Yin_val and Yin_data follow the same rule. Xin_data and Yin_data are forced to 0 when the matching val is low.
- Resulting val windows:
  - Xin_val is high for exactly X*N consecutive cycles starting the cycle after LOAD entry.
  - Yin_val is high for exactly Y*N consecutive cycles starting the same cycle.
- GAP -> START. START lasts 1 cycle with SA_start=1.
- START -> WAIT. WAIT lasts LAT cycles.
- WAIT -> DRAIN. DRAIN lasts X*Y cycles.
  - res_val=1, res_data=sa_out_data, res_idx counts 0..X*Y-1.
  - There is no backpressure: the consumer must accept every word.
- DRAIN -> DONE. DONE lasts 1 cycle with done=1. DONE -> IDLE.
- cmd_val outside IDLE is ignored; it is not queued.
- cmd_abort in any non-IDLE state forces IDLE on the next edge.
  - All outputs return to reset values at that edge; done is not asserted.
  - If SA_start is already issued, the in-flight array result is discarded.
  - cmd_abort in IDLE has no effect. cmd_abort and cmd_val in the same IDLE cycle: the command is accepted.
- Width rules: counters are sized to hold L, LAT and X*Y. res_idx wraps never; it resets on DRAIN entry.
- Back-to-back jobs: the earliest re-accept is the cycle after DONE.

Decomposition:
- Package rsa_pkg holds:
  - state enum (IDLE, LOAD, GAP, START, WAIT, DRAIN, DONE);
  - localparams L_LOAD = max(X,Y)*N and N_RES = X*Y;
  - a clog2 function.
- Optional sub-module rsa_feed_stage: the one-cycle read-valid delay plus data zero-gating, instantiated once per side (X and Y).
- FSM and counters stay in rsa_ctrl.

Test Plan:
- Default params, cmd_val at cycle 0:
  - cmd_rdy falls cycle 1; reads occur cycles 1-12 at addr 0..11;
  - Xin_val and Yin_val are high cycles 2-13; SA_start=1 only at cycle 14;
  - res_val high cycles 25-33 with res_idx 0..8; done=1 at cycle 34; cmd_rdy=1 at cycle 35.
- Asymmetric Y=2 (N=4, X=3):
  - Xin_val is high for 12 cycles, Yin_val for 8 cycles, both starting the same cycle;
  - ybuf_rd is low for k=8..11; Yin_data=0 outside its window;
  - 6 results are produced.
- Buffer data = address+1:
  - Xin_data sequence is 1..12, each word appearing the cycle after its address;
  - sa_out_data driven as the cycle count shows res_data equal to the drive value on each DRAIN cycle.
- cmd_abort during WAIT (cycle 18):
  - state is IDLE and cmd_rdy=1 at cycle 19; no res_val and no done afterwards;
  - a new cmd at cycle 19 runs the full timeline offset by 19.
- sys_rst asserted during LOAD (cycle 5) for 1 cycle: all outputs are 0 and cmd_rdy=1 from the next edge; cmd_val held through reset is accepted after release.
- cmd_val held high continuously: exactly one job per 35-cycle period; cmd_val pulses mid-job cause no effect.
